// File: rtl/spi_master_ctrl.sv
// SPI master transfer sequencer: one byte per accepted TX word, SCK/SS_n generation,
// MOSI shift-out and MISO capture, completion via rx_valid pulse and sticky spif.
module spi_master_ctrl #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spe,
   input  logic              mstr,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic [DIV_W-1:0]  div,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              spif,
   input  logic              spif_clr,
   output logic              busy,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic              ss_n
);

   // TX handshake: a word moves when tx_valid and tx_ready are both high at a clk edge;
   // tx_ready is only offered in IDLE, never in the first cycle after reset.
   typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

   localparam int EW = $clog2(2*DATA_W+1);

   state_t            state, state_d;
   logic [EW-1:0]     ecnt;
   logic [DIV_W-1:0]  cnt, div_l;
   logic              cpol_l, cpha_l, lsb_l;
   logic [DATA_W-1:0] tx_sh, rx_sh, rx_nxt, rx_data_q;
   logic              sck_q, mosi_q, rx_valid_q, spif_q, rst_q;
   logic              en, accept, abort, tick, edge_evt, leading, last_edge;
   logic              do_sample, do_shift;

   assign en        = spe & mstr;
   assign tx_ready  = (state == IDLE) & en & ~rst_q;
   assign accept    = tx_valid & tx_ready;
   assign abort     = (state != IDLE) & ~en;
   assign tick      = (state != IDLE) && (cnt == '0);
   assign edge_evt  = tick && (state == SETUP || state == XFER) && !abort;
   // ecnt counts edges already taken, so the edge about to happen is ecnt+1
   assign leading   = ~ecnt[0];
   assign last_edge = (ecnt == EW'(2*DATA_W-1));
   assign do_sample = edge_evt && (cpha_l ? !leading : leading);
   assign do_shift  = edge_evt && (cpha_l ? (leading && ecnt != '0) : (!leading && !last_edge));
   assign rx_nxt    = lsb_l ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   if (tick) state_d = XFER;
         XFER:    if (tick && last_edge) state_d = DONE;
         DONE:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q      <= 1'b1;
         cnt        <= '0;
         ecnt       <= '0;
         div_l      <= '0;
         cpol_l     <= 1'b0;
         cpha_l     <= 1'b0;
         lsb_l      <= 1'b0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         spif_q     <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         rst_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         if (spif_clr) spif_q <= 1'b0;
         if (accept) begin
            tx_sh  <= tx_data;
            rx_sh  <= '0;
            div_l  <= div;
            cnt    <= div;
            ecnt   <= '0;
            cpol_l <= cpol;
            cpha_l <= cpha;
            lsb_l  <= lsbfe;
            sck_q  <= cpol;
            mosi_q <= lsbfe ? tx_data[0] : tx_data[DATA_W-1];
         end else if (state == IDLE || abort) begin
            sck_q  <= cpol;
            mosi_q <= 1'b0;
         end else begin
            cnt <= tick ? div_l : cnt - DIV_W'(1);
            if (edge_evt) begin
               sck_q <= ~sck_q;
               ecnt  <= ecnt + EW'(1);
            end
            if (do_sample) rx_sh <= rx_nxt;
            if (do_shift) begin
               if (lsb_l) begin
                  tx_sh  <= tx_sh >> 1;
                  mosi_q <= tx_sh[1];
               end else begin
                  tx_sh  <= tx_sh << 1;
                  mosi_q <= tx_sh[DATA_W-2];
               end
            end
            // the final edge may itself carry the last sample (cpha=1)
            if (edge_evt && last_edge) begin
               rx_data_q  <= do_sample ? rx_nxt : rx_sh;
               rx_valid_q <= 1'b1;
               spif_q     <= 1'b1;
            end
            if (state == DONE && tick) begin
               mosi_q <= 1'b0;
               sck_q  <= cpol_l;
            end
         end
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign spif     = spif_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;
   assign ss_n     = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: cycle-count model of the transfer timeline compared every
// cycle, directed scenarios with literal expectations, then randomized transfers.
module tb_spi_master_ctrl;
   localparam int DW = 8;

   logic       clk = 1'b0, rst = 1'b1;
   logic       spe = 1'b1, mstr = 1'b1, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
   logic [7:0] div = 8'd0, tx_data = 8'd0;
   logic       tx_valid = 1'b0, spif_clr = 1'b0;
   logic       miso;
   logic       tx_ready, rx_valid, spif, busy, sck, mosi, ss_n;
   logic [7:0] rx_data;

   logic       loop_en = 1'b0, rand_miso = 1'b0, rand_clr = 1'b0, fall_drive = 1'b0;
   logic       miso_drv = 1'b0;
   logic [7:0] pat = 8'h00;
   int         pidx = 0;
   int         n_cmp = 0, n_err = 0;
   bit         model_en = 1'b0;

   assign miso = loop_en ? mosi : miso_drv;

   spi_master_ctrl #(.DATA_W(DW), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .spe(spe), .mstr(mstr), .cpol(cpol), .cpha(cpha),
      .lsbfe(lsbfe), .div(div), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .spif(spif),
      .spif_clr(spif_clr), .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: position in the transfer timeline as a cycle count
   int         m_active = 0, m_n = 0, m_h = 1, m_ns = 0;
   logic       m_cpol = 0, m_cpha = 0, m_lsb = 0, m_prev_rst = 1, m_idle_sck = 0, m_spif = 0;
   logic [7:0] m_tx = 0, m_rx = 0, m_rx_data = 0;

   always @(negedge clk) begin : model_p
      int e, s, idx, k, pos;
      logic x_sck, x_mosi, x_busy, x_ssn, x_rdy, x_rxv, nspif;
      if (model_en) begin
         if (m_active != 0) begin
            e = (m_n - 1) / m_h;
            if (e > 2*DW) e = 2*DW;
            if (m_cpha) s = (e == 0) ? 0 : (e - 1) / 2;
            else        s = e / 2;
            if (s > DW-1) s = DW-1;
            idx    = m_lsb ? s : DW-1-s;
            x_sck  = m_cpol ^ e[0];
            x_mosi = m_tx[idx];
            x_busy = 1'b1;
            x_ssn  = 1'b0;
            x_rdy  = 1'b0;
            x_rxv  = (m_n == 2*DW*m_h + 1);
         end else begin
            x_sck  = m_idle_sck;
            x_mosi = 1'b0;
            x_busy = 1'b0;
            x_ssn  = 1'b1;
            x_rdy  = spe & mstr & ~m_prev_rst;
            x_rxv  = 1'b0;
         end
         chk("cyc_tx_ready", tx_ready, x_rdy);
         chk("cyc_busy", busy, x_busy);
         chk("cyc_ss_n", ss_n, x_ssn);
         chk("cyc_sck", sck, x_sck);
         chk("cyc_mosi", mosi, x_mosi);
         chk("cyc_rx_valid", rx_valid, x_rxv);
         chk("cyc_rx_data", rx_data, m_rx_data);
         chk("cyc_spif", spif, m_spif);

         nspif = m_spif;
         if (rst === 1'b1) begin
            m_active = 0; m_idle_sck = 0; m_rx_data = 0; nspif = 0; m_prev_rst = 1;
         end else begin
            if (spif_clr === 1'b1) nspif = 0;
            if (m_active != 0) begin
               if (!(spe && mstr)) begin
                  m_active = 0; m_idle_sck = cpol;
               end else begin
                  if (m_n % m_h == 0 && m_n / m_h <= 2*DW) begin
                     k = m_n / m_h;
                     if ((m_cpha && k % 2 == 0) || (!m_cpha && k % 2 == 1)) begin
                        pos = m_lsb ? m_ns : DW-1-m_ns;
                        m_rx[pos] = miso;
                        m_ns++;
                     end
                  end
                  if (m_n == 2*DW*m_h) begin
                     m_rx_data = m_rx; nspif = 1;
                  end
                  if (m_n == (2*DW+1)*m_h) begin
                     m_active = 0; m_idle_sck = m_cpol;
                  end else m_n++;
               end
            end else begin
               m_idle_sck = cpol;
               if (tx_valid && x_rdy) begin
                  m_active = 1; m_n = 1; m_h = int'(div) + 1;
                  m_cpol = cpol; m_cpha = cpha; m_lsb = lsbfe;
                  m_tx = tx_data; m_rx = 0; m_ns = 0;
               end
            end
            m_prev_rst = 0;
         end
         m_spif = nspif;
      end
   end

   // observation monitors feeding the literal checks
   int busy_run = 0, last_busy = 0, ssl_run = 0, last_ssl = 0, gap_run = 0, last_gap = 0;
   int rxv_cnt = 0, sck_edges = 0;
   logic [7:0] cap = 0;
   logic sck_m = 0;
   always @(negedge clk) begin
      if (busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
      if (ss_n === 1'b0) ssl_run++;
      else if (ssl_run != 0) begin last_ssl = ssl_run; ssl_run = 0; end
      if (ss_n === 1'b1) gap_run++;
      else if (gap_run != 0) begin last_gap = gap_run; gap_run = 0; end
      if (rx_valid === 1'b1) rxv_cnt++;
      if (sck === 1'b1 && sck_m === 1'b0 && busy === 1'b1) cap = {cap[6:0], mosi};
      if (busy === 1'b1 && sck !== sck_m) sck_edges++;
      sck_m = sck;
   end

   // background drivers
   logic sck_p = 0;
   always @(posedge clk) begin
      #1;
      if (rand_clr)  spif_clr = ($urandom_range(0, 7) == 0);
      if (rand_miso) miso_drv = 1'($urandom_range(0, 1));
      if (fall_drive && sck_p && !sck && pidx < 8) begin
         miso_drv = pat[pidx];
         pidx++;
      end
      sck_p = sck;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_xfer(input logic [7:0] d);
      logic ok;
      ok = 1'b0;
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_ready === 1'b1) begin ok = 1'b1; break; end
      end
      tick();
      tx_valid = 1'b0;
      chk("accept", ok, 1'b1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin ok = 1'b1; break; end
      end
      tick();
      chk("idle_wait", ok, 1'b1);
   endtask

   task automatic wait_ready();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_ready === 1'b1) begin ok = 1'b1; break; end
      end
      tick();
      chk("ready_wait", ok, 1'b1);
   endtask

   initial begin
      tick();
      model_en = 1'b1;
      tick();
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_spif", spif, 1'b0);
      chk("rst_ss_n", ss_n, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sck", sck, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      rst = 1'b0;
      tick();

      // mode 0, MSB first, div=1, loopback
      loop_en = 1; cpol = 0; cpha = 0; lsbfe = 0; div = 8'd1;
      cap = 0; rxv_cnt = 0;
      tick();
      start_xfer(8'hA5);
      wait_idle();
      chk("t1_mosi_bits", cap, 8'hA5);
      chk("t1_rx_data", rx_data, 8'hA5);
      chk("t1_rx_valid_cnt", rxv_cnt, 1);
      chk("t1_spif", spif, 1'b1);
      chk("t1_busy_len", last_busy, 34);
      chk("t1_ss_low_len", last_ssl, 34);

      // cpol=1 cpha=1 LSB first div=0, miso from pattern on falling sck
      loop_en = 0; cpol = 1; cpha = 1; lsbfe = 1; div = 8'd0;
      pat = 8'h3C; pidx = 0; miso_drv = 0; fall_drive = 1;
      tick(); tick();
      chk("t2_sck_idle", sck, 1'b1);
      start_xfer(8'h01);
      chk("t2_first_mosi", mosi, 1'b1);
      wait_idle();
      fall_drive = 0;
      chk("t2_rx_data", rx_data, 8'h3C);
      chk("t2_busy_len", last_busy, 17);

      // back-to-back with tx_valid held high
      loop_en = 1; cpol = 0; cpha = 0; lsbfe = 0; div = 8'd0;
      tick();
      rxv_cnt = 0;
      tx_data = 8'h12; tx_valid = 1'b1;
      wait_ready();
      tx_data = 8'h34;
      wait_ready();
      tx_valid = 1'b0;
      wait_idle();
      chk("t3_rx_valid_cnt", rxv_cnt, 2);
      chk("t3_rx_data", rx_data, 8'h34);
      chk("t3_ss_gap", last_gap, 1);

      // spe dropped at the 5th sck edge
      div = 8'd1; rxv_cnt = 0; sck_edges = 0;
      start_xfer(8'hFF);
      for (int i = 0; i < 200 && sck_edges < 5; i++) tick();
      chk("t4_edges", sck_edges, 5);
      spe = 1'b0;
      tick();
      chk("t4_ss_n", ss_n, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_sck", sck, 1'b0);
      chk("t4_rx_data", rx_data, 8'h34);
      chk("t4_spif", spif, 1'b1);
      spe = 1'b1;
      repeat (3) tick();
      chk("t4_rx_valid_cnt", rxv_cnt, 0);

      // spif_clr in the cycle the completion sets spif, then alone
      div = 8'd0;
      start_xfer(8'hC3);
      repeat (15) tick();
      spif_clr = 1'b1;
      tick();
      spif_clr = 1'b0;
      chk("t5_spif_collide", spif, 1'b1);
      wait_idle();
      spif_clr = 1'b1;
      tick();
      spif_clr = 1'b0;
      chk("t5_spif_cleared", spif, 1'b0);

      // reset mid-transfer, then a clean transfer
      div = 8'd1;
      start_xfer(8'hE7);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ss_n", ss_n, 1'b1);
      chk("t6_busy", busy, 1'b0);
      chk("t6_sck", sck, 1'b0);
      chk("t6_mosi", mosi, 1'b0);
      chk("t6_tx_ready", tx_ready, 1'b0);
      chk("t6_rx_data", rx_data, 8'h00);
      chk("t6_spif", spif, 1'b0);
      tick();
      start_xfer(8'h5A);
      wait_idle();
      chk("t6_rx_after", rx_data, 8'h5A);

      // randomized transfers with live config changes, clears and aborts
      rand_clr = 1;
      for (int it = 0; it < 30; it++) begin
         loop_en   = 1'($urandom_range(0, 1));
         rand_miso = ~loop_en;
         cpol  = 1'($urandom_range(0, 1));
         cpha  = 1'($urandom_range(0, 1));
         lsbfe = 1'($urandom_range(0, 1));
         div   = 8'($urandom_range(0, 3));
         tick();
         start_xfer(8'($urandom_range(0, 255)));
         cpol    = 1'($urandom_range(0, 1));
         cpha    = 1'($urandom_range(0, 1));
         lsbfe   = 1'($urandom_range(0, 1));
         div     = 8'($urandom_range(0, 3));
         tx_data = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(0, 30)) tick();
            if ($urandom_range(0, 1) == 0) spe = 1'b0;
            else mstr = 1'b0;
            tick();
            spe = 1'b1; mstr = 1'b1;
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_clr = 0; rand_miso = 0; spif_clr = 0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
